// File: rtl/priority_enc_pkg.sv
// Shared constants and sizing helper for the priority encoder block.
// Keeps the default request width and the derived index width in one place.
package priority_enc_pkg;

    localparam int PENC_WIDTH = 4;

    // Index width for a given request count; a single request still needs one bit.
    function automatic int out_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/priority_enc_comb.sv
// Combinational lowest-set-bit encoder with reversed index (bit 0 -> WIDTH-1).
// Produces the next-state encode and any-request flag for the output register.
module priority_enc_comb
    import priority_enc_pkg::*;
#(
    parameter int WIDTH = PENC_WIDTH
) (
    input  logic [WIDTH-1:0]             D,
    output logic [out_width(WIDTH)-1:0]  y_nxt,
    output logic                         valid_nxt
);

    localparam int OUT_W = out_width(WIDTH);

    // Scan from the top down so the lowest set bit is the last to write.
    always_comb begin
        y_nxt     = '0;
        valid_nxt = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (D[i]) begin
                y_nxt     = OUT_W'(WIDTH - 1 - i);
                valid_nxt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_enc.sv
// Registered priority encoder: lowest-index request wins, index reported reversed.
// One clock of latency; outputs clear asynchronously on reset.
module priority_enc
    import priority_enc_pkg::*;
#(
    parameter int WIDTH = PENC_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             D,
    output logic [out_width(WIDTH)-1:0]  Y,
    output logic                         valid
);

    localparam int OUT_W = out_width(WIDTH);

    logic [OUT_W-1:0] y_nxt;
    logic             valid_nxt;

    priority_enc_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .D         (D),
        .y_nxt     (y_nxt),
        .valid_nxt (valid_nxt)
    );

    // Output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y     <= '0;
            valid <= 1'b0;
        end else begin
            Y     <= y_nxt;
            valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_priority_enc.sv
// Directed bench for priority_enc: expected {valid,Y} pairs are queued when D is
// driven and popped when the registered result is sampled on the falling edge.
module tb_priority_enc;

    logic       clk;
    logic       rst;
    logic [3:0] D;
    logic [1:0] Y;
    logic       valid;

    int total = 0;
    int bad   = 0;
    logic [2:0] sb_q[$];

    priority_enc dut (
        .clk   (clk),
        .rst   (rst),
        .D     (D),
        .Y     (Y),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: isolate the lowest set bit, then map it to the reversed index.
    function automatic logic [2:0] model(input logic [3:0] d);
        logic [3:0] low;
        low = d & (~d + 4'd1);
        case (low)
            4'b0001: return 3'b111;
            4'b0010: return 3'b110;
            4'b0100: return 3'b101;
            4'b1000: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed={valid,Y}=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive D, queue the expectation, sample one cycle later.
    task automatic step(input string tag, input logic [3:0] d);
        logic [2:0] exp;
        D = d;
        sb_q.push_back(model(d));
        @(posedge clk);
        @(negedge clk);
        exp = sb_q.pop_front();
        check(tag, {valid, Y}, exp);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [2:0] exp;
        rst = 1'b0;
        D   = 4'b0100;

        // 1. Asynchronous reset clears immediately and holds
        #2 rst = 1'b1;
        #1 check("reset_immediate", {valid, Y}, 3'b000);
        @(negedge clk);
        check("reset_hold_1", {valid, Y}, 3'b000);
        @(negedge clk);
        check("reset_hold_2", {valid, Y}, 3'b000);
        rst = 1'b0;
        step("reset_release_first_edge", 4'b0100);

        // 2. Sweep every request pattern
        for (int v = 0; v < 16; v++) begin
            step($sformatf("sweep_d%0d", v), 4'(v));
        end

        // 3. Priority corners
        step("all_set", 4'b1111);
        step("only_msb", 4'b1000);
        step("pair_1010", 4'b1010);
        step("pair_1100", 4'b1100);

        // 4. Latency: D changes just before the edge, glitches after it are ignored
        step("latency_idle", 4'b0000);
        @(posedge clk);
        #4 D = 4'b0010;
        sb_q.push_back(model(4'b0010));
        @(posedge clk);
        #1 exp = sb_q.pop_front();
        check("latency_after_edge", {valid, Y}, exp);
        D = 4'b1000;
        #1 D = 4'b0000;
        #1 D = 4'b0001;
        @(negedge clk);
        check("latency_hold_glitch", {valid, Y}, exp);

        // 5. Mid-cycle reset drops outputs before the next edge
        step("pre_reset_top", 4'b0001);
        @(posedge clk);
        #1 check("pre_reset_still_top", {valid, Y}, 3'b111);
        #1 rst = 1'b1;
        #1 check("midcycle_reset", {valid, Y}, 3'b000);
        @(negedge clk);
        check("midcycle_reset_hold", {valid, Y}, 3'b000);
        rst = 1'b0;
        step("resume_after_reset", 4'b0001);
        step("resume_next", 4'b0100);

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
